// File: rtl/obi_master_arbiter.sv
//------------------------------------------------------------------------------
// obi_master_arbiter
//
// Shares the single OBI master port of the SPI slave subsystem between two
// requesters: port 0 (SPI plug) and port 1 (debug / DMA engine). At most one
// transaction is outstanding. Arbitration is round-robin, and each response is
// returned to the port that issued the request.
//
// Ports
//   obi_aclk, obi_aresetn      clock, asynchronous active-low reset
//   pN_req/gnt/addr/we/w_data  address channel of requester N (N = 0, 1)
//   pN_r_valid/r_ready/r_data  response channel of requester N
//   obi_master_*               downstream OBI master port
//   busy                       high whenever the FSM is not idle
//   owner                      port index that owns the current transaction
//   timeout                    one-cycle pulse when a response times out
//
// Build option
//   OBI_ARB_TIMEOUT_EN  when defined, a response that has not arrived after
//                       TIMEOUT_CYCLES cycles in RESP is answered locally with
//                       r_data = 0. When undefined, RESP waits indefinitely
//                       and timeout is tied low.
//------------------------------------------------------------------------------
// state  | meaning
// S_IDLE | no transaction; arbitrate, absorb stray downstream responses
// S_ADDR | owner's request presented downstream, waiting for gnt
// S_RESP | request granted, waiting for the downstream response
// S_TOUT | response timed out, local error response held for the owner
//------------------------------------------------------------------------------
module obi_master_arbiter #(
   parameter int OBI_ADDR_WIDTH = 32,
   parameter int OBI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      obi_aclk,
   input  logic                      obi_aresetn,

   input  logic                      p0_req,
   output logic                      p0_gnt,
   input  logic [OBI_ADDR_WIDTH-1:0] p0_addr,
   input  logic                      p0_we,
   input  logic [OBI_DATA_WIDTH-1:0] p0_w_data,
   output logic                      p0_r_valid,
   input  logic                      p0_r_ready,
   output logic [OBI_DATA_WIDTH-1:0] p0_r_data,

   input  logic                      p1_req,
   output logic                      p1_gnt,
   input  logic [OBI_ADDR_WIDTH-1:0] p1_addr,
   input  logic                      p1_we,
   input  logic [OBI_DATA_WIDTH-1:0] p1_w_data,
   output logic                      p1_r_valid,
   input  logic                      p1_r_ready,
   output logic [OBI_DATA_WIDTH-1:0] p1_r_data,

   output logic                      obi_master_req,
   input  logic                      obi_master_gnt,
   output logic [OBI_ADDR_WIDTH-1:0] obi_master_addr,
   output logic                      obi_master_we,
   output logic [OBI_DATA_WIDTH-1:0] obi_master_w_data,
   input  logic                      obi_master_r_valid,
   output logic                      obi_master_r_ready,
   input  logic [OBI_DATA_WIDTH-1:0] obi_master_r_data,

   output logic                      busy,
   output logic                      owner,
   output logic                      timeout
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("obi_master_arbiter: TIMEOUT_CYCLES must be in 2..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_RESP = 2'd2,
      S_TOUT = 2'd3
   } state_t;

   state_t                    state;
   logic                      prio;
   logic                      own_req;
   logic                      own_r_ready;
   logic                      win;
   logic [OBI_DATA_WIDTH-1:0] r_data_mux;

   assign own_req     = owner ? p1_req     : p0_req;
   assign own_r_ready = owner ? p1_r_ready : p0_r_ready;

   // Both requesting: port prio wins; otherwise the single requester wins.
   assign win = (p0_req && p1_req) ? prio : p1_req;

`ifdef OBI_ARB_TIMEOUT_EN
   // Down-counter loaded on RESP entry. Terminal count in the (T-1)th silent
   // RESP cycle moves to S_TOUT, so the local response shows in RESP cycle T.
   localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 2);
   logic [15:0] tmr;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         state   <= S_IDLE;
         prio    <= 1'b0;
         owner   <= 1'b0;
         busy    <= 1'b0;
`ifdef OBI_ARB_TIMEOUT_EN
         tmr     <= '0;
         timeout <= 1'b0;
`endif
      end else begin
`ifdef OBI_ARB_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (p0_req || p1_req) begin
                  owner <= win;
                  state <= S_ADDR;
                  busy  <= 1'b1;
               end
            end
            S_ADDR: begin
               // Owner withdrew before grant: abandon without touching prio.
               if (!own_req) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (obi_master_gnt) begin
                  state <= S_RESP;
`ifdef OBI_ARB_TIMEOUT_EN
                  tmr   <= TMR_LOAD;
`endif
               end
            end
            S_RESP: begin
               if (obi_master_r_valid && own_r_ready) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  prio  <= ~owner;
               end
`ifdef OBI_ARB_TIMEOUT_EN
               else if (!obi_master_r_valid) begin
                  if (tmr == 16'd0) begin
                     state   <= S_TOUT;
                     timeout <= 1'b1;
                  end else begin
                     tmr <= tmr - 16'd1;
                  end
               end
`endif
            end
            S_TOUT: begin
               if (own_r_ready) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  prio  <= ~owner;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      obi_master_req     = 1'b0;
      obi_master_addr    = '0;
      obi_master_we      = 1'b0;
      obi_master_w_data  = '0;
      obi_master_r_ready = 1'b0;
      p0_gnt             = 1'b0;
      p1_gnt             = 1'b0;
      p0_r_valid         = 1'b0;
      p1_r_valid         = 1'b0;
      r_data_mux         = '0;
      unique case (state)
         S_IDLE: begin
            // Accept and drop anything downstream still wants to return.
            obi_master_r_ready = 1'b1;
         end
         S_ADDR: begin
            obi_master_req    = own_req;
            obi_master_addr   = owner ? p1_addr   : p0_addr;
            obi_master_we     = owner ? p1_we     : p0_we;
            obi_master_w_data = owner ? p1_w_data : p0_w_data;
            p0_gnt            = ~owner & obi_master_gnt;
            p1_gnt            =  owner & obi_master_gnt;
         end
         S_RESP: begin
            obi_master_r_ready = own_r_ready;
            p0_r_valid         = ~owner & obi_master_r_valid;
            p1_r_valid         =  owner & obi_master_r_valid;
            r_data_mux         = obi_master_r_data;
         end
         S_TOUT: begin
            // Local error response; data stays zero and downstream is not
            // acknowledged, so a late response is absorbed later in IDLE.
            p0_r_valid = ~owner;
            p1_r_valid =  owner;
         end
      endcase
   end

   assign p0_r_data = r_data_mux;
   assign p1_r_data = r_data_mux;

endmodule
